// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : ps2_pkg
//  Brief   : Shared types and constants for the PS/2 host transmitter.
//  Revision: 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_tx_state_t;

    // data bits + parity + stop
    localparam int PS2_FRAME_BITS = 10;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/ps2_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module  : ps2_sync_edge
//  Brief   : 3-flop synchroniser for a raw PS/2 pin plus falling-edge detect.
//  Revision: 1.0 - initial release
// ============================================================================
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic fall
);

    logic [2:0] r_sync;
    logic       r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 3'b000;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[1:0], async_in};
            r_prev <= r_sync[2];
        end
    end

    assign sync_out = r_sync[2];
    assign fall     = r_prev & ~r_sync[2];

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module  : ps2_host_tx
//  Brief   : Host-to-device PS/2 command transmitter with ACK check/watchdog.
//  Revision: 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int REQ_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    import ps2_pkg::*;

    localparam int c_INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int c_REQ_W = $clog2(REQ_CYCLES + 1);
    localparam int c_WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_INH_W-1:0] c_INH_LAST = c_INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_REQ_W-1:0] c_REQ_LAST = c_REQ_W'(REQ_CYCLES - 1);
    localparam logic [c_WD_W-1:0]  c_WD_LAST  = c_WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]         c_LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    ps2_tx_state_t               r_state, w_state_n;
    logic [PS2_FRAME_BITS-1:0]   r_shreg, w_shreg_n;
    logic [3:0]                  r_cnt, w_cnt_n;
    logic [c_INH_W-1:0]          r_inh, w_inh_n;
    logic [c_REQ_W-1:0]          r_req, w_req_n;
    logic [c_WD_W-1:0]           r_wd, w_wd_n;
    logic                        r_clk_oe, w_clk_oe_n;
    logic                        r_data_oe, w_data_oe_n;

    logic w_clk_s, w_clk_fall, w_data_s, w_data_fall_unused;
    logic w_wd_expired;

    ps2_sync_edge u_sync_clk (
        .clk      (clk),
        .rst      (rst),
        .async_in (ps2_clk),
        .sync_out (w_clk_s),
        .fall     (w_clk_fall)
    );

    ps2_sync_edge u_sync_data (
        .clk      (clk),
        .rst      (rst),
        .async_in (ps2_data),
        .sync_out (w_data_s),
        .fall     (w_data_fall_unused)
    );

    assign w_wd_expired = (r_wd == c_WD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_cnt     <= 4'd0;
            r_inh     <= '0;
            r_req     <= '0;
            r_wd      <= '0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_shreg   <= w_shreg_n;
            r_cnt     <= w_cnt_n;
            r_inh     <= w_inh_n;
            r_req     <= w_req_n;
            r_wd      <= w_wd_n;
            r_clk_oe  <= w_clk_oe_n;
            r_data_oe <= w_data_oe_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_shreg_n   = r_shreg;
        w_cnt_n     = r_cnt;
        w_inh_n     = r_inh;
        w_req_n     = r_req;
        w_wd_n      = r_wd;
        w_clk_oe_n  = r_clk_oe;
        w_data_oe_n = r_data_oe;
        tx_done     = 1'b0;
        tx_err      = 1'b0;

        case (r_state)
            IDLE: begin
                w_clk_oe_n  = 1'b0;
                w_data_oe_n = 1'b0;
                if (tx_valid) begin
                    w_shreg_n  = {1'b1, ~^tx_data, tx_data};
                    w_cnt_n    = 4'd0;
                    w_inh_n    = '0;
                    w_clk_oe_n = 1'b1;
                    w_state_n  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (r_inh == c_INH_LAST) begin
                    w_req_n     = '0;
                    w_data_oe_n = 1'b1;
                    w_state_n   = REQ;
                end else begin
                    w_inh_n = r_inh + 1'b1;
                end
            end
            REQ: begin
                if (r_req == c_REQ_LAST) begin
                    w_clk_oe_n = 1'b0;
                    w_wd_n     = '0;
                    w_state_n  = SEND;
                end else begin
                    w_req_n = r_req + 1'b1;
                end
            end
            SEND: begin
                // An edge on the terminal count wins over the watchdog.
                if (w_clk_fall) begin
                    w_data_oe_n = ~r_shreg[0];
                    w_shreg_n   = {1'b0, r_shreg[PS2_FRAME_BITS-1:1]};
                    w_cnt_n     = r_cnt + 4'd1;
                    w_wd_n      = '0;
                    if (r_cnt == c_LAST_BIT) begin
                        w_state_n = ACK;
                    end
                end else if (w_wd_expired) begin
                    w_data_oe_n = 1'b0;
                    tx_err      = 1'b1;
                    w_state_n   = IDLE;
                end else begin
                    w_wd_n = r_wd + 1'b1;
                end
            end
            ACK: begin
                w_data_oe_n = 1'b0;
                if (w_clk_fall) begin
                    w_wd_n = '0;
                    if (w_data_s) begin
                        tx_err    = 1'b1;
                        w_state_n = IDLE;
                    end else begin
                        w_state_n = WAIT_IDLE;
                    end
                end else if (w_wd_expired) begin
                    tx_err    = 1'b1;
                    w_state_n = IDLE;
                end else begin
                    w_wd_n = r_wd + 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (w_clk_s && w_data_s) begin
                    tx_done   = 1'b1;
                    w_state_n = IDLE;
                end else if (w_wd_expired) begin
                    tx_err    = 1'b1;
                    w_state_n = IDLE;
                end else begin
                    w_wd_n = r_wd + 1'b1;
                end
            end
            default: begin
                w_clk_oe_n  = 1'b0;
                w_data_oe_n = 1'b0;
                w_state_n   = IDLE;
            end
        endcase
    end

    assign tx_ready    = (r_state == IDLE);
    assign tx_busy     = ~tx_ready;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module  : tb_ps2_host_tx
//  Brief   : Bench for ps2_host_tx with an open-drain PS/2 device model.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    import ps2_pkg::*;

    localparam int c_INH  = 20;
    localparam int c_REQ  = 4;
    localparam int c_TMO  = 200;
    localparam int c_SYNC = 3;

    typedef struct {
        logic [7:0] data;
        logic       ack;
        int         nfalls;
        logic       exp_done;
        logic       exp_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx_busy, tx_done, tx_err;
    logic       ps2_clk, ps2_data, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    // open-drain bus: either side may pull low
    assign ps2_clk  = dev_clk & ~ps2_clk_oe;
    assign ps2_data = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (c_INH),
        .REQ_CYCLES     (c_REQ),
        .TIMEOUT_CYCLES (c_TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   done_cnt = 0, err_cnt = 0, both_cnt = 0, acc_cnt = 0, err_cyc = 0;
    int   clk_oe_run = 0, last_clk_oe_run = 0, data_rise_cyc = 0, last_lead = 0;
    int   first_rel_cyc = 0;
    logic armed = 1'b0, prev_clk_oe = 1'b0, prev_data_oe = 1'b0;

    always @(negedge clk) begin
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_err) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (tx_done && tx_err) both_cnt <= both_cnt + 1;
        if (tx_valid && tx_ready) acc_cnt <= acc_cnt + 1;
        if (ps2_data_oe && !prev_data_oe) data_rise_cyc <= cyc;
        if (ps2_clk_oe) begin
            clk_oe_run <= clk_oe_run + 1;
        end else if (prev_clk_oe) begin
            last_clk_oe_run <= clk_oe_run;
            last_lead       <= cyc - data_rise_cyc;
            clk_oe_run      <= 0;
            armed           <= 1'b1;
        end
        if (armed && prev_data_oe && !ps2_data_oe && !ps2_clk_oe) begin
            first_rel_cyc <= cyc;
            armed         <= 1'b0;
        end
        prev_clk_oe  <= ps2_clk_oe;
        prev_data_oe <= ps2_data_oe;
    end

    int n_checks = 0, n_pass = 0;
    int last_fall_cyc = 0, first_fall_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame as it should appear on the wire: 8 data bits LSB first, odd parity, stop.
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        logic [9:0] f;
        for (int i = 0; i < 8; i++) f[i] = b[i];
        f[8] = ($countones(b) % 2 == 0);
        f[9] = 1'b1;
        return f;
    endfunction

    task automatic send(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        for (int k = 0; k < 5000; k++) begin
            if (tx_ready) begin
                tick(1);
                tx_valid = 1'b0;
                return;
            end
            tick(1);
        end
        n_checks++;
        $display("FAIL accept: tx_ready=%0b, required 1 within 5000 cycles", tx_ready);
        tx_valid = 1'b0;
    endtask

    task automatic device(input int nfalls, input logic ack, input int half,
                          output logic [9:0] bits);
        logic seen;
        seen = 1'b0;
        bits = '0;
        for (int k = 0; k < 500 && !seen; k++) begin
            @(negedge clk);
            seen = !ps2_clk_oe && ps2_data_oe;
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL device_req: clk_oe=%0b data_oe=%0b, required 0/1", ps2_clk_oe, ps2_data_oe);
            tick(1);
            return;
        end
        tick(half);
        for (int i = 0; i < nfalls && i < 11; i++) begin
            if (i == 10 && ack) begin
                dev_data = 1'b0;
                tick(1);
            end
            dev_clk = 1'b0;
            last_fall_cyc = cyc;
            if (i == 0) first_fall_cyc = cyc;
            tick(half);
            dev_clk = 1'b1;
            if (i < 10) bits[i] = ps2_data;
            tick(half);
        end
        dev_data = 1'b1;
    endtask

    task automatic finish_xfer(input string tag);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(negedge clk);
            got = tx_done || tx_err;
        end
        if (!got) begin
            n_checks++;
            $display("FAIL %s_end: done=%0b err=%0b, required a pulse", tag, tx_done, tx_err);
        end else begin
            @(negedge clk);
            chk({tag, "_ready"}, 32'(tx_ready), 1);
            chk({tag, "_oe"}, 32'({ps2_clk_oe, ps2_data_oe}), 0);
        end
        tick(1);
    endtask

    task automatic xfer(input string tag, input logic [7:0] b, input int nfalls,
                        input logic ack, input int half, input logic exp_done,
                        input logic exp_err, output logic [9:0] bits);
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send(b);
        fork
            device(nfalls, ack, half, bits);
            finish_xfer(tag);
        join
        chk({tag, "_done"}, done_cnt - d0, 32'(exp_done));
        chk({tag, "_err"}, err_cnt - e0, 32'(exp_err));
        if (nfalls >= 10) chk({tag, "_frame"}, 32'(bits), 32'(model_frame(b)));
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: cycle %0d, required finish", cyc);
        $fatal(1, "bench did not finish");
    end

    vec_t       vecs [5];
    logic [9:0] bits;
    logic [7:0] rb;
    logic       rack;
    int         rhalf, d0, e0, a0;
    logic       ok;

    initial begin
        vecs[0] = '{PS2_CMD_SET_LED, 1'b1, 11, 1'b1, 1'b0};
        vecs[1] = '{PS2_CMD_ENABLE,  1'b1, 11, 1'b1, 1'b0};
        vecs[2] = '{8'h00,           1'b0, 11, 1'b0, 1'b1};
        vecs[3] = '{PS2_CMD_RESET,   1'b1, 11, 1'b1, 1'b0};
        vecs[4] = '{8'h5A,           1'b1, 4,  1'b0, 1'b1};

        tick(3);
        chk("rst_ready", 32'(tx_ready), 1);
        chk("rst_busy", 32'(tx_busy), 0);
        chk("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 0);
        chk("rst_done", 32'(tx_done), 0);
        chk("rst_err", 32'(tx_err), 0);
        rst = 1'b0;
        tick(5);

        for (int v = 0; v < 5; v++) begin
            xfer($sformatf("vec%0d", v), vecs[v].data, vecs[v].nfalls, vecs[v].ack, 40,
                 vecs[v].exp_done, vecs[v].exp_err, bits);
            if (v == 0) begin
                chk("ed_bits", 32'(bits), 32'(10'b11_1110_1101));
                chk("pin_to_oe", first_rel_cyc - first_fall_cyc, 4);
            end
            if (v == 1) begin
                chk("f4_parity", 32'(bits[8]), 0);
                chk("f4_clk_oe_len", last_clk_oe_run, c_INH + c_REQ);
                chk("f4_data_lead", last_lead, c_REQ);
            end
            // the watchdog counts from the synchronised fall, 3 cycles after the pin
            if (v == 4) chk("tmo_gap", err_cyc - last_fall_cyc, c_TMO + c_SYNC);
        end

        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h3C);
        device(6, 1'b0, 40, bits);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 0);
        chk("midrst_ready", 32'(tx_ready), 1);
        chk("midrst_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
        tick(5);
        xfer("after_rst", PS2_CMD_RESET, 11, 1'b1, 40, 1'b1, 1'b0, bits);
        chk("after_rst_parity", 32'(bits[8]), 1);

        a0 = acc_cnt;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            ok = tx_ready;
            tick(1);
        end
        tx_data = 8'h3C;
        fork
            device(11, 1'b1, 40, bits);
            finish_xfer("hold1");
        join
        tx_valid = 1'b0;
        chk("hold1_frame", 32'(bits), 32'(model_frame(8'hA5)));
        chk("hold_accepts", acc_cnt - a0, 2);
        fork
            device(11, 1'b1, 40, bits);
            finish_xfer("hold2");
        join
        chk("hold2_frame", 32'(bits), 32'(model_frame(8'h3C)));

        for (int r = 0; r < 6; r++) begin
            rb    = 8'($urandom);
            rack  = ($urandom_range(0, 3) != 0);
            rhalf = int'($urandom_range(20, 60));
            xfer($sformatf("rnd%0d", r), rb, 11, rack, rhalf, rack, !rack, bits);
        end

        chk("no_done_err_overlap", both_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: serialises one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) onto the open-drain PS/2 clock/data pair and checks the device's acknowledge bit. It is the reverse-direction companion of `ps2_keyboard`, which owns device-to-host reception. Both sit in `top` on the same `ps2_clk`/`ps2_data` pins. `tx_busy` lets the receiver ignore the edges this block provokes.

## Interface
- `INHIBIT_CYCLES`, default 5000: clk-low inhibit time (100 µs at 50 MHz).
- `REQ_CYCLES`, default 16: both lines held low before the clock is released.
- `TIMEOUT_CYCLES`, default 1000000: maximum wait between device clock falling edges, or for bus idle.
- `clk` input, 1 bit: system clock; all logic is rising-edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `tx_valid` input, 1 bit: request to send `tx_data`.
- `tx_data` input, 8 bits: command byte.
- `tx_ready` output, 1 bit: high in IDLE; a transfer is accepted on a cycle where `tx_valid & tx_ready`.
- `tx_busy` output, 1 bit: equals `~tx_ready`.
- `tx_done` output, 1 bit: one-cycle pulse when the ACK is received and the bus has returned to idle.
- `tx_err` output, 1 bit: one-cycle pulse on NACK or timeout.
- `ps2_clk` input, 1 bit: raw pin level (asynchronous).
- `ps2_data` input, 1 bit: raw pin level (asynchronous).
- `ps2_clk_oe` output, 1 bit: 1 = pull PS/2 clock low; 0 = release.
- `ps2_data_oe` output, 1 bit: 1 = pull PS/2 data low; 0 = release.

## Operation
- Input conditioning:
  - `ps2_clk` and `ps2_data` each pass through a 3-flop synchroniser.
  - `fall` = synchronised clk was 1 on the previous sample and is 0 now.
- Accepting a byte:
  - On acceptance, latch `shreg = {1'b1 (stop), ~^tx_data (odd parity), tx_data}`, 10 bits.
  - Clear the bit counter `cnt`.
- State machine:
  - IDLE: both OE = 0. On accept → INHIBIT.
  - INHIBIT: `clk_oe` = 1, `data_oe` = 0 for INHIBIT_CYCLES cycles → REQ.
  - REQ: `clk_oe` = 1, `data_oe` = 1 (start bit) for REQ_CYCLES cycles → SEND.
  - SEND: `clk_oe` = 0. On each `fall`:
    - drive `data_oe = ~shreg[0]`, shift `shreg` right, increment `cnt`;
    - data bits go out LSB first, followed by parity, followed by stop (data released);
    - after the 10th `fall`, go to ACK.
  - ACK: on the next `fall`, sample synchronised data. 0 → WAIT_IDLE. 1 → pulse `tx_err`, go to IDLE.
  - WAIT_IDLE: when synchronised clk and data are both 1, pulse `tx_done` and go to IDLE.
- Timeout:
  - A watchdog counter runs in SEND, ACK and WAIT_IDLE, and is cleared on every `fall` and on every state entry.
  - When it reaches TIMEOUT_CYCLES: both OE = 0, pulse `tx_err`, go to IDLE.
  - `tx_done` and `tx_err` never assert in the same cycle.
- Simultaneous events:
  - `tx_valid` while busy is ignored; there is no queue, and the requester holds `tx_valid` until `tx_ready`.
  - A `fall` that coincides with the timeout terminal count counts as an edge; the timeout does not fire.
- Reset: `rst` asserted in any state returns to IDLE on the next edge. Reset values:
  - OE outputs 0, `tx_done` 0, `tx_err` 0, `tx_ready` 1, `tx_busy` 0;
  - `shreg`, `cnt`, watchdog and synchronisers all 0.
- Width rules:
  - `cnt` is 4 bits.
  - The INHIBIT, REQ and watchdog counters are each sized `$clog2` of their parameter + 1.

## Timing
- Acceptance to `ps2_clk_oe` = 1: 1 cycle (registered outputs).
- `clk_oe` is high for INHIBIT_CYCLES + REQ_CYCLES cycles.
- `data_oe` rises REQ_CYCLES cycles before `clk_oe` falls.
- Bit k is driven 1 cycle after the cycle in which its synchronised `fall` is detected. Pin edge to OE change: 4 cycles (3 synchroniser cycles + 1 register).
- ACK is sampled on the 11th `fall`.
- `tx_done` fires at the first cycle where both synchronised lines are high after the ACK.
- `tx_ready` returns 1 in the cycle after the `tx_done`/`tx_err` pulse.

## Structure
- Package `ps2_pkg`:
  - `ps2_tx_state_t` enum {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE};
  - `PS2_FRAME_BITS = 10`;
  - command constants `PS2_CMD_SET_LED = 8'hED`, `PS2_CMD_ENABLE = 8'hF4`, `PS2_CMD_RESET = 8'hFF`.
- Sub-module `ps2_sync_edge`: 3-flop synchroniser plus falling-edge detector. It is instantiated once for clk (with edge output) and once for data; `ps2_keyboard` can later reuse it.

## Test plan
- Bench parameters: INHIBIT_CYCLES = 20, REQ_CYCLES = 4.
- Send 0xED with a device model clocking at 40 cycles/half-period and ACKing → serial bits 1,0,1,1,0,1,1,1, parity 1, stop 1; then `tx_done` pulses once and `tx_err` stays 0.
- Send 0xF4 → parity bit 0; `clk_oe` high for exactly 24 cycles; `data_oe` rises 4 cycles before `clk_oe` falls.
- Device model leaves data high on the ACK edge → `tx_err` pulses once; IDLE with both OE = 0 on the next cycle.
- Device stops clocking after bit 3, with TIMEOUT_CYCLES = 200 → `tx_err` pulses exactly 200 cycles after the last `fall`; `tx_ready` = 1 after it.
- Assert `rst` for 1 cycle during SEND at bit 5 → next cycle both OE = 0 and `tx_ready` = 1. A following 0xFF transfer then completes normally, with parity 1.
- Hold `tx_valid` high across a transfer with `tx_data` changed mid-transfer → the in-flight frame is unchanged; the second byte is accepted only once `tx_ready` = 1.
